switch_arbiter: RTL and testbench
=================================

Name: switch_arbiter

Overview:
Central scheduler for the switch fabric. It takes transmit requests (validtx/adr_i/dat_i) from NP port blocks, grants one requester at a time in round-robin order, and writes the granted word into the destination port's output FIFO via a shared write bus (fifo_o plus a one-hot wen). It completes a 4-phase validtx/acktx handshake with the source port. Requesters whose destination FIFO is full are skipped, so one full port never blocks the others.

Parameters:
DW, 4, data width of one word
NP, 4, number of ports; fixed at 4 because adr_i is 2 bits per port
TO_W, 4, width of the ACK watchdog counter; used only with SWITCH_TIMEOUT_EN

Ports:
clk_i  input  1  single clock
rst_i  input  1  asynchronous, active-high reset
validtx  input  NP  per-port transmit request, level
adr_i  input  2*NP  destination address; port p uses bits [2p+1:2p]
dat_i  input  DW*NP  data; port p uses bits [DW*p+DW-1:DW*p]
acktx  output  NP  per-port acknowledge, one-hot or zero
fifo_o  output  DW  shared write data to all port FIFOs
wen  output  NP  one-hot write enable to the destination FIFO
full  input  NP  full flag from each destination FIFO
busy  output  1  high in any state other than IDLE
err  output  1  watchdog abort pulse; exists only with SWITCH_TIMEOUT_EN

Behaviour:
- One clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset values: state=IDLE, acktx=0, wen=0, fifo_o=0, busy=0, err=0, rr_ptr=0, src=0, dst=0.
- All outputs are registered. No combinational path from any input to any output.
- Eligibility: port p is eligible when validtx[p]=1 and full[adr_i[p]]=0.
- Loopback is allowed: adr_i[p]==p is legal.
- State IDLE:
  - Pick the first eligible port, searching from rr_ptr upward modulo NP.
  - If one is found, latch src, dst and data, and go to WRITE.
  - If none is found, stay in IDLE.
- State WRITE (exactly 1 cycle):
  - wen[dst]=1 and fifo_o=latched data.
  - Next state is ACK.
  - full is not re-checked here; eligibility was checked at grant.
- State ACK:
  - acktx[src]=1 and wen=0.
  - Stay until validtx[src]=0 is sampled; then acktx goes to 0, rr_ptr becomes src+1 (mod NP), and state returns to IDLE.
- Latency: a request sampled at edge k gives wen high in cycle k+1 and acktx high from cycle k+2.
- Minimum handshake length is 4 cycles per word, including the IDLE cycle.
- Requests that appear or change while busy are ignored until the next IDLE.
- Data and address are captured at grant; changes during ACK are ignored.
- A full destination only defers its requester; other eligible ports are granted meanwhile.
- If all requesters target full FIFOs, the block stays in IDLE with no outputs asserted.
- rr_ptr wraps from NP-1 to 0.
- Asserting rst_i mid-transfer returns to IDLE immediately.
  - wen and acktx drop asynchronously.
  - A word already written stays in the FIFO; the source retries if validtx is still high.
- Illegal or unused state encodings go to IDLE.

Optional Feature:
SWITCH_TIMEOUT_EN
- Defined:
  - A TO_W-bit counter clears on entry to ACK and increments each ACK cycle.
  - If it reaches 2^TO_W-1 while validtx[src] is still 1: acktx drops, err pulses high for 1 cycle, rr_ptr becomes src+1, and state returns to IDLE.
  - The word is not rewritten.
- Not defined:
  - No counter and no err port; ACK waits indefinitely.

Decomposition:
- Shared package switch_pkg holds:
  - state enum {IDLE, WRITE, ACK}
  - NP_DEF=4 and ADR_W=2
  - helper function onehot(idx) returning an NP-bit vector
- One sub-module, rr_arbiter. It is purely combinational: inputs are the request vector and rr_ptr; outputs are grant_valid and a grant index.
- The FSM, data capture and watchdog stay in switch_arbiter.

Test Plan:
- Single transfer: port1 validtx=1, adr=2, dat=0xA, no FIFO full → wen=0100 and fifo_o=0xA for one cycle at k+1; acktx=0010 from k+2; port1 drops validtx → acktx=0 next edge, busy=0.
- Round-robin: ports 0,1,3 request continuously, each targeting a non-full port → grant order 0,1,3,0,1,3; no port granted twice before the others.
- Full skip: port0→dst2 with full[2]=1, port3→dst1 with full[1]=0 → port3 served first; port0 served after full[2] falls.
- Loopback: port2 adr=2, dat=0x5 → wen=0100, fifo_o=0x5, acktx=0100.
- Reset mid-ACK: assert rst_i while acktx=0001 → acktx, wen, busy all 0 without a clock edge; after release, port0 still requesting is regranted.
- SWITCH_TIMEOUT_EN with TO_W=2: hold validtx[0] high in ACK → after 3 ACK cycles acktx=0 and err pulses once; the next requester, port1, is granted.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch fabric scheduler.
package switch_pkg;

  localparam int unsigned NP_DEF = 4;
  localparam int unsigned ADR_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

  // Port index to one-hot port vector.
  function automatic logic [NP_DEF-1:0] onehot(input logic [ADR_W-1:0] idx);
    logic [NP_DEF-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/switch_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, modulo NP.
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned NP = NP_DEF
) (
  input  logic [NP-1:0]    req,
  input  logic [ADR_W-1:0] ptr,
  output logic             grant_valid,
  output logic [ADR_W-1:0] grant_idx
);

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    logic [ADR_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      cand = ADR_W'((32'(ptr) + i) % NP);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/switch_arbiter.sv
// Central switch scheduler: round-robin grant, one-cycle FIFO write, 4-phase
// validtx/acktx handshake with the source. Optional ACK watchdog with err
// output is enabled by defining SWITCH_TIMEOUT_EN.
module switch_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned DW   = 4,
  parameter int unsigned NP   = 4,
  parameter int unsigned TO_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NP-1:0]     validtx,
  input  logic [2*NP-1:0]   adr_i,
  input  logic [DW*NP-1:0]  dat_i,
  output logic [NP-1:0]     acktx,
  output logic [DW-1:0]     fifo_o,
  output logic [NP-1:0]     wen,
  input  logic [NP-1:0]     full,
  output logic              busy
`ifdef SWITCH_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  state_e           state_q, state_d;
  logic [ADR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ADR_W-1:0] src_q, src_d;
  logic [ADR_W-1:0] dst_q, dst_d;
  logic [DW-1:0]    data_q, data_d;
  logic [NP-1:0]    elig;
  logic             gnt_valid;
  logic [ADR_W-1:0] gnt_idx;

`ifdef SWITCH_TIMEOUT_EN
  // Abort on the ACK cycle in which the counter would step to all-ones.
  localparam logic [TO_W-1:0] CntLast = {{(TO_W-1){1'b1}}, 1'b0};
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // A requester is eligible only if its destination FIFO has room.
  always_comb begin
    elig = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      elig[p] = validtx[p] & ~full[adr_i[2*p +: ADR_W]];
    end
  end

  rr_arbiter #(
    .NP(NP)
  ) u_rr (
    .req        (elig),
    .ptr        (rr_ptr_q),
    .grant_valid(gnt_valid),
    .grant_idx  (gnt_idx)
  );

  // Next-state logic: grant in IDLE, write for one cycle, then hold ACK.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    dst_d    = dst_q;
    data_d   = data_q;
`ifdef SWITCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          src_d   = gnt_idx;
          dst_d   = adr_i[2*gnt_idx +: ADR_W];
          data_d  = dat_i[DW*gnt_idx +: DW];
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = ACK;
`ifdef SWITCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACK: begin
        if (!validtx[src_q]) begin
          state_d  = IDLE;
          rr_ptr_d = src_q + 1'b1;
        end
`ifdef SWITCH_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          state_d  = IDLE;
          rr_ptr_d = src_q + 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
`ifdef SWITCH_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
`ifdef SWITCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs decode from registers only, so reset clears them without a clock.
  assign busy   = (state_q != IDLE);
  assign wen    = (state_q == WRITE) ? NP'(onehot(dst_q)) : '0;
  assign acktx  = (state_q == ACK) ? NP'(onehot(src_q)) : '0;
  assign fifo_o = data_q;
`ifdef SWITCH_TIMEOUT_EN
  assign err    = err_q;
`endif

endmodule

// File: tb/tb_switch_arbiter.sv
// Self-checking bench for switch_arbiter (default build).
module tb_switch_arbiter;

  logic        clk;
  logic        rst_i;
  logic [3:0]  validtx;
  logic [7:0]  adr_i;
  logic [15:0] dat_i;
  logic [3:0]  acktx;
  logic [3:0]  fifo_o;
  logic [3:0]  wen;
  logic [3:0]  full;
  logic        busy;
`ifdef SWITCH_TIMEOUT_EN
  logic        err;
`endif

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  switch_arbiter #(
    .DW(4),
    .NP(4),
    .TO_W(4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .validtx(validtx),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .acktx  (acktx),
    .fifo_o (fifo_o),
    .wen    (wen),
    .full   (full),
    .busy   (busy)
`ifdef SWITCH_TIMEOUT_EN
    ,
    .err    (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [7:0]  a;
    logic [15:0] d;
    logic [3:0]  f;
    logic        g;
    logic [3:0]  ew;
    logic [3:0]  ef;
    logic [3:0]  ea;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [3:0] oh(input int i);
    return 4'(1) << i;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
  task automatic run_txn(input string nm, input logic [3:0] v, input logic [7:0] a,
                         input logic [15:0] d, input logic [3:0] f, input logic g,
                         input logic [3:0] ew, input logic [3:0] ef, input logic [3:0] ea,
                         input int hold);
    validtx = v; adr_i = a; dat_i = d; full = f;
    @(negedge clk);
    if (!g) begin
      chk({nm, " idle_wen"}, 32'(wen), 32'h0);
      chk({nm, " idle_ack"}, 32'(acktx), 32'h0);
      chk({nm, " idle_busy"}, 32'(busy), 32'h0);
    end else begin
      chk({nm, " wen"}, 32'(wen), 32'(ew));
      chk({nm, " fifo"}, 32'(fifo_o), 32'(ef));
      chk({nm, " write_ack"}, 32'(acktx), 32'h0);
      chk({nm, " write_busy"}, 32'(busy), 32'h1);
      for (int h = 0; h <= hold; h++) begin
        // Inputs other than the source's validtx must not matter while busy.
        validtx = 4'($urandom) | ea;
        adr_i   = 8'($urandom);
        dat_i   = 16'($urandom);
        full    = 4'($urandom);
        @(negedge clk);
        chk({nm, " ack"}, 32'(acktx), 32'(ea));
        chk({nm, " ack_wen"}, 32'(wen), 32'h0);
        chk({nm, " ack_busy"}, 32'(busy), 32'h1);
      end
      validtx = validtx & ~ea;
      @(negedge clk);
      chk({nm, " rel_ack"}, 32'(acktx), 32'h0);
      chk({nm, " rel_busy"}, 32'(busy), 32'h0);
      chk({nm, " rel_wen"}, 32'(wen), 32'h0);
      m_ptr = (idx_of(ea) + 1) % 4;
    end
  endtask

  initial begin
    logic [3:0]  v, f, ew, ef, ea;
    logic [7:0]  a;
    logic [15:0] d;
    logic        g;
    int          src;
    int          rr_order[6];
    logic [3:0]  rr_wen[4];
    logic [3:0]  rr_dat[4];

    // {validtx, adr_i, dat_i, full, granted, wen, fifo_o, acktx}, run from ptr=0
    tbl[0] = '{4'b1001, 8'h42, 16'hC003, 4'b0100, 1'b1, 4'b0010, 4'hC, 4'b1000}; // full skip
    tbl[1] = '{4'b1001, 8'h42, 16'hC003, 4'b0000, 1'b1, 4'b0100, 4'h3, 4'b0001}; // deferred
    tbl[2] = '{4'b0010, 8'h08, 16'h00A0, 4'b0000, 1'b1, 4'b0100, 4'hA, 4'b0010}; // single
    tbl[3] = '{4'b0100, 8'h20, 16'h0500, 4'b0000, 1'b1, 4'b0100, 4'h5, 4'b0100}; // loopback
    tbl[4] = '{4'b1111, 8'h00, 16'h1234, 4'b0001, 1'b0, 4'b0000, 4'h0, 4'b0000}; // all full
    tbl[5] = '{4'b0011, 8'h03, 16'h0097, 4'b0000, 1'b1, 4'b1000, 4'h7, 4'b0001}; // wrap

    rst_i = 1'b1; validtx = '0; adr_i = '0; dat_i = '0; full = '0;
    @(negedge clk);
    chk("reset acktx", 32'(acktx), 32'h0);
    chk("reset wen", 32'(wen), 32'h0);
    chk("reset fifo", 32'(fifo_o), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].f, tbl[i].g,
              tbl[i].ew, tbl[i].ef, tbl[i].ea, i % 3);
    end

    // Round-robin: ports 0,1,3 keep requesting; pointer sits at 1 here.
    rr_order = '{1, 3, 0, 1, 3, 0};
    rr_wen   = '{4'b0010, 4'b0100, 4'b0000, 4'b0001};
    rr_dat   = '{4'h1, 4'h2, 4'h0, 4'h4};
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("rr%0d", i), 4'b1011, 8'h09, 16'h4021, 4'b0000, 1'b1,
              rr_wen[rr_order[i]], rr_dat[rr_order[i]], oh(rr_order[i]), 0);
    end

    // Reset during ACK clears outputs without a clock, then port 0 is regranted.
    validtx = 4'b0001; adr_i = 8'h01; dat_i = 16'h0006; full = '0;
    @(negedge clk);
    chk("rst wen", 32'(wen), 32'h2);
    @(negedge clk);
    chk("rst pre_ack", 32'(acktx), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst async_ack", 32'(acktx), 32'h0);
    chk("rst async_wen", 32'(wen), 32'h0);
    chk("rst async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    m_ptr = 0;
    run_txn("rst_regrant", 4'b0001, 8'h01, 16'h0006, 4'b0000, 1'b1,
            4'b0010, 4'h6, 4'b0001, 1);

    // Randomized traffic against a transaction-level round-robin model.
    for (int t = 0; t < 40; t++) begin
      v = 4'($urandom);
      a = 8'($urandom);
      d = 16'($urandom);
      f = 4'($urandom) & 4'($urandom);
      g = 1'b0;
      src = 0;
      for (int off = 0; off < 4; off++) begin
        int p;
        p = (m_ptr + off) % 4;
        if (!g && v[p] && !f[a[2*p +: 2]]) begin
          g   = 1'b1;
          src = p;
        end
      end
      ew = g ? oh(int'(a[2*src +: 2])) : 4'b0000;
      ef = d[4*src +: 4];
      ea = oh(src);
      run_txn($sformatf("rand%0d", t), v, a, d, f, g, ew, ef, ea, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
